bounded_counter_rr_arbiter: RTL

Owns a bounded increment counter pair (sn, i) and shares it round-robin among NREQ requesters. Each granted requester may commit up to MAX_BURST single-step increments before the grant rotates. Once i passes LIMIT the counter is exhausted: no further grants are issued until reset. The block sits between requesting agents and the bounded counter datapath and replaces a free-running enable.

---
 rtl/bounded_counter_rr_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bounded_counter_rr_arbiter.sv
// Round-robin arbiter sharing a bounded (sn, i) increment counter among NREQ requesters.
// Each grant commits up to MAX_BURST increments; once i passes LIMIT the block locks until rst.
module bounded_counter_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 10,
    parameter int LIMIT     = 300,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [2:0]       owner,
    output logic [WIDTH-1:0] sn,
    output logic [WIDTH-1:0] i,
    output logic             exhausted
);

    localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        EXHAUSTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [WIDTH-1:0] sn_q, sn_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic            exhausted_q, exhausted_d;

    logic            pick_valid;
    logic [2:0]      pick_idx;
    logic            below_limit;
    logic            owner_req;
    logic            release_now;

    assign below_limit = (i_q <= LIMIT_W);
    // gnt is one-hot on the owner, so masking req with it yields req[owner]
    assign owner_req   = |(req & gnt_q);

    // Scan downward so the requester closest to the pointer wins the final overwrite
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr_q) + k) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = 3'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
        sn_d        = sn_q;
        i_d         = i_q;
        exhausted_d = exhausted_q;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid && below_limit) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    burst_d = '0;
                end
            end
            GRANT: begin
                if (owner_req && below_limit) begin
                    sn_d    = sn_q + WIDTH'(1);
                    i_d     = i_q + WIDTH'(1);
                    burst_d = burst_q + BW'(1);
                    if (burst_q == BW'(MAX_BURST - 1) || i_q == LIMIT_W)
                        release_now = 1'b1;
                end else begin
                    release_now = 1'b1;
                end

                if (release_now) begin
                    gnt_d    = '0;
                    rr_ptr_d = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
                    if (i_d > LIMIT_W) begin
                        state_d     = EXHAUSTED;
                        exhausted_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            EXHAUSTED: begin
                gnt_d = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
            sn_q        <= '0;
            i_q         <= WIDTH'(1);
            exhausted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
            sn_q        <= sn_d;
            i_q         <= i_d;
            exhausted_q <= exhausted_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign sn        = sn_q;
    assign i         = i_q;
    assign exhausted = exhausted_q;

endmodule
